// File: rtl/branch_resolve_pkg.sv
// Shared encodings for branch resolution: op codes, comparator result codes,
// resolver FSM states and the redirect target calculation.
package branch_resolve_pkg;

  typedef enum logic [2:0] {
    OpNone = 3'd0,
    OpBeq  = 3'd1,
    OpBne  = 3'd2,
    OpBltu = 3'd3,
    OpBgeu = 3'd4,
    OpBgtu = 3'd5,
    OpBleu = 3'd6,
    OpJmp  = 3'd7
  } br_op_e;

  typedef enum logic [1:0] {
    BRANCH_DEFAULT = 2'b00,
    BRANCH_EQUAL   = 2'b01,
    BRANCH_LT      = 2'b10,
    BRANCH_GT      = 2'b11
  } cmp_code_e;

  typedef enum logic [0:0] {
    StIdle     = 1'b0,
    StRedirect = 1'b1
  } br_state_e;

  // Branches are PC-relative word offsets; JMP keeps the upper 4 PC bits.
  function automatic logic [31:0] calc_target(input logic [2:0]  op,
                                              input logic [31:0] pc,
                                              input logic [15:0] imm);
    logic [31:0] target;
    if (op == OpJmp) begin
      target = {pc[31:28], 10'b0, imm, 2'b00};
    end else begin
      target = pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
    end
    return target;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational taken decision from branch op and unsigned compare result.
module branch_cond
  import branch_resolve_pkg::*;
(
  input  logic [2:0] br_op,
  input  logic [1:0] cmp_code,
  output logic       taken
);

  cmp_code_e cmp;
  logic      is_eq, is_lt, is_gt;

  assign cmp   = cmp_code_e'(cmp_code);
  assign is_eq = (cmp == BRANCH_EQUAL);
  assign is_lt = (cmp == BRANCH_LT);
  assign is_gt = (cmp == BRANCH_GT);

  // BRANCH_DEFAULT leaves all three flags low, so only JMP can be taken.
  always_comb begin
    taken = 1'b0;
    case (br_op_e'(br_op))
      OpBeq:   taken = is_eq;
      OpBne:   taken = is_lt | is_gt;
      OpBltu:  taken = is_lt;
      OpBgeu:  taken = is_eq | is_gt;
      OpBgtu:  taken = is_gt;
      OpBleu:  taken = is_eq | is_lt;
      OpJmp:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolver: accepts resolved branches from ID, issues a held fetch
// redirect plus a one-cycle IF/ID flush for taken ones, and keeps statistics.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_op,
  input  logic [1:0]       cmp_code,
  input  logic [31:0]      br_pc,
  input  logic [15:0]      br_imm,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [31:0]      redirect_target,
  output logic             flush_ifid,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  br_state_e        state_q, state_d;
  logic             taken;
  logic             accept;
  logic             take;
  logic             count_en;
  logic [31:0]      target_q;
  logic             flush_q;
  logic [CNT_W-1:0] br_count_q, taken_count_q;

  branch_cond u_branch_cond (
    .br_op    (br_op),
    .cmp_code (cmp_code),
    .taken    (taken)
  );

  assign accept   = br_valid && br_ready;
  assign take     = accept && taken;
  assign count_en = accept && (br_op != OpNone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (take) state_d = StRedirect;
      StRedirect: if (redirect_ready) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    br_ready       = (state_q == StIdle);
    redirect_valid = (state_q == StRedirect);
  end

  // Flush is only ever set on the acceptance edge, so it covers exactly the
  // first redirect cycle regardless of how long fetch stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= RESET_PC;
      flush_q  <= 1'b0;
    end else begin
      flush_q <= take;
      if (take) begin
        target_q <= calc_target(br_op, br_pc, br_imm);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else begin
      if (count_en && (br_count_q != '1)) begin
        br_count_q <= br_count_q + CNT_W'(1);
      end
      if (take && (taken_count_q != '1)) begin
        taken_count_q <= taken_count_q + CNT_W'(1);
      end
    end
  end

  assign redirect_target = target_q;
  assign flush_ifid      = flush_q;
  assign br_count        = br_count_q;
  assign taken_count     = taken_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve.
module tb_branch_resolve;

  localparam logic [31:0] RstPc = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_valid = 1'b0;
  logic [2:0]  br_op = 3'd0;
  logic [1:0]  cmp_code = 2'b00;
  logic [31:0] br_pc = 32'h0;
  logic [15:0] br_imm = 16'h0;
  logic        redirect_ready = 1'b1;

  logic        br_ready, redirect_valid, flush_ifid;
  logic [31:0] redirect_target;
  logic [15:0] br_count, taken_count;

  logic        br_ready4, redirect_valid4, flush_ifid4;
  logic [31:0] redirect_target4;
  logic [3:0]  br_count4, taken_count4;

  int unsigned n_checks = 0;
  int unsigned n_bad = 0;

  logic [3:0] taken_mask [8];

  always #5 clk = ~clk;

  branch_resolve #(.CNT_W(16), .RESET_PC(RstPc)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .br_valid        (br_valid),
    .br_ready        (br_ready),
    .br_op           (br_op),
    .cmp_code        (cmp_code),
    .br_pc           (br_pc),
    .br_imm          (br_imm),
    .redirect_valid  (redirect_valid),
    .redirect_ready  (redirect_ready),
    .redirect_target (redirect_target),
    .flush_ifid      (flush_ifid),
    .br_count        (br_count),
    .taken_count     (taken_count)
  );

  branch_resolve #(.CNT_W(4)) dut4 (
    .clk             (clk),
    .rst_n           (rst_n),
    .br_valid        (br_valid),
    .br_ready        (br_ready4),
    .br_op           (br_op),
    .cmp_code        (cmp_code),
    .br_pc           (br_pc),
    .br_imm          (br_imm),
    .redirect_valid  (redirect_valid4),
    .redirect_ready  (redirect_ready),
    .redirect_target (redirect_target4),
    .flush_ifid      (flush_ifid4),
    .br_count        (br_count4),
    .taken_count     (taken_count4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after acceptance.
  task automatic send(input logic [2:0] op, input logic [1:0] cmp,
                      input logic [31:0] pc, input logic [15:0] imm);
    br_valid = 1'b1;
    br_op    = op;
    cmp_code = cmp;
    br_pc    = pc;
    br_imm   = imm;
    @(posedge clk);
    #1;
    br_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    taken_mask[0] = 4'b0000; // NONE
    taken_mask[1] = 4'b0010; // BEQ
    taken_mask[2] = 4'b1100; // BNE
    taken_mask[3] = 4'b0100; // BLTU
    taken_mask[4] = 4'b1010; // BGEU
    taken_mask[5] = 4'b1000; // BGTU
    taken_mask[6] = 4'b0110; // BLEU
    taken_mask[7] = 4'b1111; // JMP

    #12;
    check_eq("rst_rv", 32'(redirect_valid), 32'd0);
    check_eq("rst_flush", 32'(flush_ifid), 32'd0);
    check_eq("rst_target", redirect_target, RstPc);
    check_eq("rst_brcnt", 32'(br_count), 32'd0);
    check_eq("rst_tkcnt", 32'(taken_count), 32'd0);
    do_reset();
    check_eq("rel_ready", 32'(br_ready), 32'd1);

    // BEQ taken
    send(3'd1, 2'b01, 32'h0000_0100, 16'h0004);
    check_eq("beq_rv", 32'(redirect_valid), 32'd1);
    check_eq("beq_target", redirect_target, 32'h0000_0114);
    check_eq("beq_flush", 32'(flush_ifid), 32'd1);
    check_eq("beq_ready", 32'(br_ready), 32'd0);
    @(posedge clk); #1;
    check_eq("beq_rv_done", 32'(redirect_valid), 32'd0);
    check_eq("beq_flush_done", 32'(flush_ifid), 32'd0);
    check_eq("beq_ready_back", 32'(br_ready), 32'd1);

    // BNE not taken
    send(3'd2, 2'b01, 32'h0000_0200, 16'h0008);
    check_eq("bne_rv", 32'(redirect_valid), 32'd0);
    check_eq("bne_flush", 32'(flush_ifid), 32'd0);
    check_eq("bne_ready", 32'(br_ready), 32'd1);
    check_eq("bne_brcnt", 32'(br_count), 32'd2);
    check_eq("bne_tkcnt", 32'(taken_count), 32'd1);

    // BLTU taken, negative offset, fetch stalls three cycles
    redirect_ready = 1'b0;
    send(3'd3, 2'b10, 32'h0000_2000, 16'hFFFE);
    check_eq("bltu_rv", 32'(redirect_valid), 32'd1);
    check_eq("bltu_target", redirect_target, 32'h0000_1FFC);
    check_eq("bltu_flush", 32'(flush_ifid), 32'd1);
    check_eq("bltu_ready", 32'(br_ready), 32'd0);
    br_valid = 1'b1; br_op = 3'd7; cmp_code = 2'b00; br_pc = 32'h8000_0000; br_imm = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("bltu_hold_rv", 32'(redirect_valid), 32'd1);
      check_eq("bltu_hold_target", redirect_target, 32'h0000_1FFC);
      check_eq("bltu_hold_flush", 32'(flush_ifid), 32'd0);
      check_eq("bltu_hold_ready", 32'(br_ready), 32'd0);
    end
    redirect_ready = 1'b1;
    br_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("bltu_rv_done", 32'(redirect_valid), 32'd0);
    check_eq("bltu_ready_back", 32'(br_ready), 32'd1);
    check_eq("bltu_brcnt", 32'(br_count), 32'd3);
    check_eq("bltu_tkcnt", 32'(taken_count), 32'd2);

    // BGEU target wraps past 2^32
    send(3'd4, 2'b11, 32'hFFFF_FFF8, 16'h0001);
    check_eq("wrap_rv", 32'(redirect_valid), 32'd1);
    check_eq("wrap_target", redirect_target, 32'h0000_0000);
    @(posedge clk); #1;

    // JMP, then reset while the redirect is pending
    redirect_ready = 1'b0;
    send(3'd7, 2'b00, 32'h4000_0000, 16'h0010);
    check_eq("jmp_rv", 32'(redirect_valid), 32'd1);
    check_eq("jmp_target", redirect_target, 32'h4000_0040);
    check_eq("jmp_brcnt", 32'(br_count), 32'd5);
    check_eq("jmp_tkcnt", 32'(taken_count), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rv", 32'(redirect_valid), 32'd0);
    check_eq("mid_rst_flush", 32'(flush_ifid), 32'd0);
    check_eq("mid_rst_target", redirect_target, RstPc);
    check_eq("mid_rst_brcnt", 32'(br_count), 32'd0);
    check_eq("mid_rst_tkcnt", 32'(taken_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_rv", 32'(redirect_valid), 32'd0);
    check_eq("post_rst_flush", 32'(flush_ifid), 32'd0);
    check_eq("post_rst_ready", 32'(br_ready), 32'd1);

    // NONE is not counted; DEFAULT compare is never taken
    send(3'd0, 2'b01, 32'h0000_0100, 16'h0004);
    check_eq("none_rv", 32'(redirect_valid), 32'd0);
    check_eq("none_brcnt", 32'(br_count), 32'd0);
    send(3'd6, 2'b00, 32'h0000_0100, 16'h0004);
    check_eq("bleu_def_rv", 32'(redirect_valid), 32'd0);
    check_eq("bleu_def_brcnt", 32'(br_count), 32'd1);
    send(3'd5, 2'b11, 32'h0000_0100, 16'h0000);
    check_eq("bgtu_target", redirect_target, 32'h0000_0104);
    check_eq("bgtu_tkcnt", 32'(taken_count), 32'd1);
    @(posedge clk); #1;

    // Full op x compare decision table
    for (int op = 0; op < 8; op++) begin
      for (int c = 0; c < 4; c++) begin
        send(3'(op), 2'(c), 32'h0000_1000, 16'h0001);
        check_eq($sformatf("tbl_rv_op%0d_c%0d", op, c), 32'(redirect_valid),
                 32'(taken_mask[op][c]));
        if (taken_mask[op][c]) begin
          check_eq($sformatf("tbl_tgt_op%0d_c%0d", op, c), redirect_target,
                   (op == 7) ? 32'h0000_0004 : 32'h0000_1008);
          @(posedge clk); #1;
        end
      end
    end
    check_eq("tbl_brcnt", 32'(br_count), 32'd30);
    check_eq("tbl_tkcnt", 32'(taken_count), 32'd14);

    // Saturation with a 4-bit counter instance
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send(3'd1, 2'b01, 32'h0000_0000, 16'h0000);
      if (i == 0) begin
        check_eq("sat_rv4", 32'(redirect_valid4), 32'd1);
        check_eq("sat_target4", redirect_target4, 32'h0000_0004);
        check_eq("sat_flush4", 32'(flush_ifid4), 32'd1);
        check_eq("sat_ready4", 32'(br_ready4), 32'd0);
      end
      @(posedge clk); #1;
    end
    check_eq("sat_brcnt4", 32'(br_count4), 32'd15);
    check_eq("sat_tkcnt4", 32'(taken_count4), 32'd15);
    check_eq("sat_brcnt16", 32'(br_count), 32'd20);
    check_eq("sat_tkcnt16", 32'(taken_count), 32'd20);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
